// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the four-way round-robin mux arbiter.
package mux_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {IDLE, GRANT} arb_state_t;
    typedef logic [N_REQ-1:0] req_vec_t;

    function automatic req_vec_t onehot(input logic [SEL_W-1:0] idx);
        return req_vec_t'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority picker: returns the first set bit of vec, searching
// upward from start and wrapping modulo four.
module rr_pick4
    import mux_arb_pkg::*;
(
    input  req_vec_t               vec,
    input  logic [SEL_W-1:0]       start,
    output logic                   found,
    output logic [SEL_W-1:0]       idx
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = start;
        cand  = start;
        for (int k = 0; k < N_REQ; k++) begin
            cand = start + SEL_W'(k);
            if (!found && vec[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner selection for a shared 4:1 mux, with voluntary release,
// direct hand-off and forced release after MAX_HOLD cycles under contention.
module mux4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             valid,
    output logic             preempt
);

    localparam int HW = $clog2(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    arb_state_t       state_q, state_d;
    req_vec_t         gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             valid_q, valid_d;
    logic             preempt_q, preempt_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [HW-1:0]    hold_q, hold_d;

    req_vec_t         others;
    logic             owner_req;
    logic             expired;
    logic             release_now;
    req_vec_t         pick_vec;
    logic [SEL_W-1:0] pick_start;
    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;

    // The owner is always sel_q while granted; it is excluded from the hand-off search.
    assign others      = req & ~onehot(sel_q);
    assign owner_req   = req[sel_q];
    assign expired     = (hold_q == HOLD_LAST) && (others != '0);
    assign release_now = (state_q == GRANT) && (!owner_req || expired);
    assign pick_vec    = (state_q == IDLE) ? req : others;
    assign pick_start  = (state_q == IDLE) ? ptr_q : sel_q + 2'd1;

    rr_pick4 u_pick (
        .vec   (pick_vec),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        valid_d   = valid_q;
        preempt_d = 1'b0;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    gnt_d   = onehot(pick_idx);
                    sel_d   = pick_idx;
                    valid_d = 1'b1;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    ptr_d     = sel_q + 2'd1;
                    // A drop that coincides with expiry counts as voluntary.
                    preempt_d = owner_req;
                    if (pick_found) begin
                        gnt_d  = onehot(pick_idx);
                        sel_d  = pick_idx;
                        hold_d = '0;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        valid_d = 1'b0;
                    end
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            sel_q     <= '0;
            valid_q   <= 1'b0;
            preempt_q <= 1'b0;
            ptr_q     <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            valid_q   <= valid_d;
            preempt_q <= preempt_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
        end
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign valid   = valid_q;
    assign preempt = preempt_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed vector table, hand-written hold/expiry
// sequences, and a long random run checked against a behavioural model.
module tb_mux4_rr_arbiter;

    localparam int MAX_HOLD = 8;
    localparam int STARVE_BOUND = 3 * MAX_HOLD + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       preempt;

    int errors = 0;
    int checks = 0;

    mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .sel     (sel),
        .valid   (valid),
        .preempt (preempt)
    );

    always #5 clk = ~clk;

    // Behavioural model: owner index (-1 when idle), pointer, hold age.
    int m_owner = -1;
    int m_sel   = 0;
    int m_ptr   = 0;
    int m_hold  = 0;
    bit m_pre   = 1'b0;
    int wait_cnt [4];

    function automatic int search(input logic [3:0] v, input int start);
        for (int k = 0; k < 4; k++) begin
            if (v[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_update(input bit r, input logic [3:0] rq);
        int w;
        logic [3:0] oth;
        bit vol;
        bit exp_hit;
        if (r) begin
            m_owner = -1; m_sel = 0; m_ptr = 0; m_hold = 0; m_pre = 1'b0;
        end else if (m_owner < 0) begin
            m_pre = 1'b0;
            w = search(rq, m_ptr);
            if (w >= 0) begin
                m_owner = w; m_sel = w; m_hold = 0;
            end
        end else begin
            oth = rq;
            oth[m_owner] = 1'b0;
            vol = !rq[m_owner];
            exp_hit = (m_hold >= MAX_HOLD - 1) && (oth != 4'b0000);
            m_pre = 1'b0;
            if (vol || exp_hit) begin
                m_ptr = (m_owner + 1) % 4;
                m_pre = !vol;
                w = search(oth, m_ptr);
                if (w >= 0) begin
                    m_owner = w; m_sel = w; m_hold = 0;
                end else begin
                    m_owner = -1;
                end
            end else if (m_hold < MAX_HOLD - 1) begin
                m_hold = m_hold + 1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // One clock: drive inputs, advance model, sample #1 after the edge.
    task automatic step(input bit r, input logic [3:0] rq);
        logic [3:0] mg;
        rst = r;
        req = rq;
        @(posedge clk);
        model_update(r, rq);
        #1;
        mg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        chk("model_gnt", 32'(gnt), 32'(mg));
        chk("model_sel", 32'(sel), 32'(m_sel));
        chk("model_valid", 32'(valid), 32'(m_owner >= 0));
        chk("model_preempt", 32'(preempt), 32'(m_pre));
        for (int i = 0; i < 4; i++) begin
            if (r) begin
                wait_cnt[i] = 0;
            end else if (gnt[i]) begin
                if (wait_cnt[i] > 0) chk("starve_bound", 32'(wait_cnt[i] <= STARVE_BOUND), 32'd1);
                wait_cnt[i] = 0;
            end else if (rq[i]) begin
                wait_cnt[i]++;
            end else begin
                wait_cnt[i] = 0;
            end
        end
    endtask

    typedef struct {
        bit         rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] sel;
        bit         valid;
        bit         pre;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit r, input logic [3:0] rq, input logic [3:0] g,
                                input logic [1:0] s, input bit v, input bit p);
        vec_t e;
        e.rst = r; e.req = rq; e.gnt = g; e.sel = s; e.valid = v; e.pre = p;
        tbl.push_back(e);
    endfunction

    logic [3:0] rreq;

    initial begin
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;

        // Reset held with all requests high, then first grant from ptr=0.
        add(1, 4'b1111, 4'b0000, 2'd0, 0, 0);
        add(1, 4'b1111, 4'b0000, 2'd0, 0, 0);
        add(1, 4'b1111, 4'b0000, 2'd0, 0, 0);
        add(0, 4'b1111, 4'b0001, 2'd0, 1, 0);
        add(0, 4'b0000, 4'b0000, 2'd0, 0, 0);
        // Single requester 2 for three cycles; sel retained while idle; ptr then 3.
        add(0, 4'b0100, 4'b0100, 2'd2, 1, 0);
        add(0, 4'b0100, 4'b0100, 2'd2, 1, 0);
        add(0, 4'b0100, 4'b0100, 2'd2, 1, 0);
        add(0, 4'b0000, 4'b0000, 2'd2, 0, 0);
        add(0, 4'b0000, 4'b0000, 2'd2, 0, 0);
        add(0, 4'b1001, 4'b1000, 2'd3, 1, 0);
        add(0, 4'b0000, 4'b0000, 2'd3, 0, 0);
        // Fairness: owners drop after two grant cycles, hand-off without bubbles.
        add(0, 4'b1111, 4'b0001, 2'd0, 1, 0);
        add(0, 4'b1111, 4'b0001, 2'd0, 1, 0);
        add(0, 4'b1110, 4'b0010, 2'd1, 1, 0);
        add(0, 4'b1111, 4'b0010, 2'd1, 1, 0);
        add(0, 4'b1101, 4'b0100, 2'd2, 1, 0);
        add(0, 4'b1111, 4'b0100, 2'd2, 1, 0);
        add(0, 4'b1011, 4'b1000, 2'd3, 1, 0);
        add(0, 4'b1111, 4'b1000, 2'd3, 1, 0);
        add(0, 4'b0111, 4'b0001, 2'd0, 1, 0);
        add(0, 4'b0000, 4'b0000, 2'd0, 0, 0);
        // Mid-grant reset, then search restarts at ptr=0.
        add(0, 4'b0100, 4'b0100, 2'd2, 1, 0);
        add(0, 4'b0100, 4'b0100, 2'd2, 1, 0);
        add(0, 4'b0100, 4'b0100, 2'd2, 1, 0);
        add(0, 4'b0100, 4'b0100, 2'd2, 1, 0);
        add(1, 4'b0110, 4'b0000, 2'd0, 0, 0);
        add(0, 4'b0110, 4'b0010, 2'd1, 1, 0);
        add(0, 4'b0000, 4'b0000, 2'd1, 0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].req);
            chk($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
            chk($sformatf("tbl%0d_sel", i), 32'(sel), 32'(tbl[i].sel));
            chk($sformatf("tbl%0d_valid", i), 32'(valid), 32'(tbl[i].valid));
            chk($sformatf("tbl%0d_preempt", i), 32'(preempt), 32'(tbl[i].pre));
        end

        // Contention on ports 0 and 1: alternate every MAX_HOLD cycles.
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < MAX_HOLD; c++) begin
                step(0, 4'b0011);
                chk("alt_gnt", 32'(gnt), (r % 2 == 0) ? 32'h1 : 32'h2);
                chk("alt_preempt", 32'(preempt), 32'((c == 0) && (r > 0)));
            end
        end
        step(0, 4'b0000);
        chk("alt_end_valid", 32'(valid), 32'd0);

        // Expiry without a competitor keeps the grant; a late requester preempts.
        for (int c = 0; c < 20; c++) begin
            step(0, 4'b1000);
            chk("solo_gnt", 32'(gnt), 32'h8);
            chk("solo_preempt", 32'(preempt), 32'd0);
        end
        step(0, 4'b1010);
        chk("late_gnt", 32'(gnt), 32'h2);
        chk("late_preempt", 32'(preempt), 32'd1);
        step(0, 4'b1010);
        chk("late_pulse_width", 32'(preempt), 32'd0);
        step(0, 4'b1000);
        chk("handback_gnt", 32'(gnt), 32'h8);
        step(0, 4'b0000);

        // Owner drop on the expiry edge is voluntary: no preempt pulse.
        step(0, 4'b0001);
        chk("coinc_first", 32'(gnt), 32'h1);
        for (int c = 0; c < MAX_HOLD - 1; c++) step(0, 4'b0011);
        chk("coinc_still_owner", 32'(gnt), 32'h1);
        step(0, 4'b0010);
        chk("coinc_gnt", 32'(gnt), 32'h2);
        chk("coinc_preempt", 32'(preempt), 32'd0);
        step(0, 4'b0000);

        // Random run against the model.
        rreq = 4'b0000;
        for (int n = 0; n < 1500; n++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 3) == 0) rreq[b] = ~rreq[b];
            end
            step($urandom_range(0, 199) == 0, rreq);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
